// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the oversampling UART receiver.
//   rx_state_t    : receive state machine encoding
//   ERR_*         : bit positions of the per-character error flags
//   dataBitCount  : turns the 2-bit character-length select into 5..8
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   localparam int ERR_PARITY = 0;
   localparam int ERR_FRAME  = 1;
   localparam int ERR_BREAK  = 2;

   // The select value is an offset from the shortest character (5 bits).
   function automatic logic [3:0] dataBitCount(input logic [1:0] sel);
      return 4'd5 + {2'b00, sel};
   endfunction

endpackage

// File: rtl/sync_fifo_fwft_with_clear.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft_with_clear
// Single-clock first-word-fall-through FIFO with a synchronous flush.
//   clk, rst_n        : clock, synchronous active-low reset
//   clear_i           : flush; wins over a same-cycle read or write
//   wr_en_i/wr_data_i : push (ignored when full unless a pop happens too)
//   rd_en_i           : pop head (ignored when empty)
//   rd_data_o         : head entry
//   empty_o, full_o   : status
// ---------------------------------------------------------------------------
module sync_fifo_fwft_with_clear #(
   parameter int DATA_WIDTH            = 8,
   parameter int DEPTH                 = 16,
   parameter int EXTRA_OUTPUT_REGISTER = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  empty_o,
   output logic                  full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]           wrPtr_q;
   logic [AW:0]           rdPtr_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  push;
   logic                  pop;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

   // A push into a full FIFO is allowed only when the head leaves in the same cycle.
   assign push = wr_en_i & ~clear_i & (~full_o | rd_en_i);
   assign pop  = rd_en_i & ~clear_i & ~empty_o;

   // Pointer bookkeeping; a flush simply realigns both pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else if (clear_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   // Storage array; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
   end

   generate
      if (EXTRA_OUTPUT_REGISTER != 0) begin : g_outReg
         logic [DATA_WIDTH-1:0] head_q;
         // Optional retiming stage on the head path at the cost of a cycle of latency.
         always_ff @(posedge clk) begin
            if (!rst_n) head_q <= '0;
            else        head_q <= mem_q[rdPtr_q[AW-1:0]];
         end
         assign rd_data_o = head_q;
      end else begin : g_noOutReg
         assign rd_data_o = mem_q[rdPtr_q[AW-1:0]];
      end
   endgenerate

endmodule

// File: rtl/uart_rx_os_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_os_sampler
// Line conditioning and bit timing for the receiver.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_os_tick    : oversample tick (baud x OVERSAMPLE)
//   i_uart_rx    : raw asynchronous serial line
//   i_restart    : realign the bit-time counter (start-bit edge seen)
//   o_rx_sync    : synchronised line
//   o_fall_edge  : synchronised high-to-low transition
//   o_strobe     : one-cycle pulse at the third sample of each bit
//   o_vote       : 2-of-3 majority of the samples, valid with o_strobe
// ---------------------------------------------------------------------------
module uart_rx_os_sampler #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_os_tick,
   input  logic i_uart_rx,
   input  logic i_restart,
   output logic o_rx_sync,
   output logic o_fall_edge,
   output logic o_strobe,
   output logic o_vote
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int MID   = OVERSAMPLE / 2;
   localparam logic [CNT_W:0]   PT_EARLY = (CNT_W+1)'(MID - 1);
   localparam logic [CNT_W:0]   PT_MID   = (CNT_W+1)'(MID);
   localparam logic [CNT_W:0]   PT_LATE  = (CNT_W+1)'(MID + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             prev_q;
   logic [CNT_W-1:0] tickCnt_q;
   logic [CNT_W:0]   nextCnt;
   logic             early_q;
   logic             mid_q;
   logic             tickRun;

   assign tickRun     = i_os_tick & ~i_restart;
   assign nextCnt     = {1'b0, tickCnt_q} + (CNT_W+1)'(1);
   assign o_rx_sync   = sync2_q;
   assign o_fall_edge = prev_q & ~sync2_q;
   assign o_strobe    = tickRun && (nextCnt == PT_LATE);
   assign o_vote      = (early_q & mid_q) | (early_q & sync2_q) | (mid_q & sync2_q);

   // Two-flop synchroniser plus a delayed copy for edge detection. Everything
   // idles high so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= i_uart_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Position inside the current bit, counted in os ticks from the start edge.
   // The two earlier vote samples are captured here; the third is the live
   // synchronised line at the strobe tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tickCnt_q <= '0;
         early_q   <= 1'b1;
         mid_q     <= 1'b1;
      end else if (i_restart) begin
         tickCnt_q <= '0;
      end else if (i_os_tick) begin
         tickCnt_q <= (tickCnt_q == CNT_LAST) ? '0 : nextCnt[CNT_W-1:0];
         if (nextCnt == PT_EARLY) early_q <= sync2_q;
         if (nextCnt == PT_MID)   mid_q   <= sync2_q;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver with error-tagged RX FIFO.
//   clk, rst_n                  : clock, synchronous active-low reset
//   i_os_tick                   : oversample tick (baud x OVERSAMPLE)
//   i_uart_rx                   : asynchronous serial input
//   i_data_bits/i_parity_en/
//   i_parity_odd/i_stop_bits    : frame format, captured at start detection
//   i_fifo_clear/i_fifo_rd_en   : flush / pop head
//   i_rx_threshold              : level interrupt threshold, 0 disables
//   o_fifo_rd_data/o_fifo_rd_err: head character and {break, frame, parity}
//   o_fifo_empty/full/level     : FIFO status
//   o_threshold, o_timeout      : level and idle-timeout interrupts
//   o_overflow/underflow_error  : one-cycle error pulses
// ---------------------------------------------------------------------------
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int OVERSAMPLE   = 16,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_os_tick,
   input  logic                            i_uart_rx,
   input  logic [1:0]                      i_data_bits,
   input  logic                            i_parity_en,
   input  logic                            i_parity_odd,
   input  logic                            i_stop_bits,
   input  logic                            i_fifo_clear,
   input  logic                            i_fifo_rd_en,
   input  logic [$clog2(FIFO_DEPTH+1)-1:0] i_rx_threshold,
   output logic [7:0]                      o_fifo_rd_data,
   output logic [2:0]                      o_fifo_rd_err,
   output logic                            o_fifo_empty,
   output logic                            o_fifo_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_level,
   output logic                            o_threshold,
   output logic                            o_timeout,
   output logic                            o_overflow_error,
   output logic                            o_underflow_error
);

   localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W    = $clog2(OVERSAMPLE);
   localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TO_LIMIT);
   localparam logic [TO_W-1:0]  TO_PRE    = TO_W'(TO_LIMIT - 1);

   rx_state_t        state_q;
   logic [3:0]       nBits_q;
   logic             parEn_q;
   logic             parOdd_q;
   logic             twoStop_q;
   logic [2:0]       bitCnt_q;
   logic [7:0]       data_q;
   logic             parAcc_q;
   logic             parBit_q;
   logic             parErr_q;
   logic             frameErr_q;
   logic             break_q;
   logic [CNT_W-1:0] idleCnt_q;
   logic             wrEn_q;
   logic [10:0]      wrEntry_q;

   logic             rxSync;
   logic             fallEdge;
   logic             strobe;
   logic             vote;
   logic             startDet;
   logic             lastDataBit;
   logic             lastStop;
   logic             frameNow;
   logic             breakNow;
   logic [2:0]       errNow;

   logic [10:0]      rdEntry;
   logic             fifoEmpty;
   logic             fifoFull;
   logic             pushOk;
   logic             popOk;
   logic [LVL_W-1:0] level_q;
   logic             threshold_q;
   logic             overflow_q;
   logic             underflow_q;
   logic [TO_W-1:0]  toCnt_q;
   logic             timeout_q;

   assign startDet = (state_q == IDLE) && fallEdge;

   uart_rx_os_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_os_tick   (i_os_tick),
      .i_uart_rx   (i_uart_rx),
      .i_restart   (startDet),
      .o_rx_sync   (rxSync),
      .o_fall_edge (fallEdge),
      .o_strobe    (strobe),
      .o_vote      (vote)
   );

   // Flags as they will stand after the current stop sample. A break is
   // judged on stop 1; a second stop bit can only add a frame error. Parity is
   // meaningless on a break, so it is not reported alongside one.
   always_comb begin
      lastDataBit        = ({1'b0, bitCnt_q} == (nBits_q - 4'd1));
      lastStop           = (bitCnt_q != 3'd0) || !twoStop_q;
      frameNow           = frameErr_q | ~vote;
      breakNow           = (bitCnt_q == 3'd0) ? (~vote & (data_q == 8'd0) & ~parBit_q)
                                              : break_q;
      errNow             = 3'b000;
      errNow[ERR_BREAK]  = breakNow;
      errNow[ERR_FRAME]  = frameNow;
      errNow[ERR_PARITY] = parErr_q & ~breakNow;
   end

   // Receive state machine. Every bit decision happens on a sampler strobe;
   // the finished character is registered and written the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         nBits_q    <= 4'd8;
         parEn_q    <= 1'b0;
         parOdd_q   <= 1'b0;
         twoStop_q  <= 1'b0;
         bitCnt_q   <= '0;
         data_q     <= '0;
         parAcc_q   <= 1'b0;
         parBit_q   <= 1'b0;
         parErr_q   <= 1'b0;
         frameErr_q <= 1'b0;
         break_q    <= 1'b0;
         idleCnt_q  <= '0;
         wrEn_q     <= 1'b0;
         wrEntry_q  <= '0;
      end else begin
         wrEn_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fallEdge) begin
                  state_q    <= START;
                  nBits_q    <= dataBitCount(i_data_bits);
                  parEn_q    <= i_parity_en;
                  parOdd_q   <= i_parity_odd;
                  twoStop_q  <= i_stop_bits;
                  bitCnt_q   <= '0;
                  data_q     <= '0;
                  parAcc_q   <= 1'b0;
                  parBit_q   <= 1'b0;
                  parErr_q   <= 1'b0;
                  frameErr_q <= 1'b0;
                  break_q    <= 1'b0;
               end
            end
            START: begin
               if (strobe) state_q <= vote ? IDLE : DATA;
            end
            DATA: begin
               if (strobe) begin
                  data_q[bitCnt_q] <= vote;
                  parAcc_q         <= parAcc_q ^ vote;
                  if (lastDataBit) begin
                     bitCnt_q <= '0;
                     state_q  <= parEn_q ? PARITY : STOP;
                  end else begin
                     bitCnt_q <= bitCnt_q + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (strobe) begin
                  parBit_q <= vote;
                  parErr_q <= (vote != (parAcc_q ^ parOdd_q));
                  state_q  <= STOP;
               end
            end
            STOP: begin
               if (strobe) begin
                  frameErr_q <= frameNow;
                  break_q    <= breakNow;
                  if (lastStop) begin
                     wrEn_q    <= 1'b1;
                     wrEntry_q <= {errNow, data_q};
                     idleCnt_q <= '0;
                     state_q   <= frameNow ? WAIT_IDLE : IDLE;
                  end else begin
                     bitCnt_q <= 3'd1;
                  end
               end
            end
            WAIT_IDLE: begin
               if (!rxSync) begin
                  idleCnt_q <= '0;
               end else if (i_os_tick) begin
                  if (idleCnt_q == IDLE_LAST) state_q <= IDLE;
                  else                        idleCnt_q <= idleCnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sync_fifo_fwft_with_clear #(
      .DATA_WIDTH            (11),
      .DEPTH                 (FIFO_DEPTH),
      .EXTRA_OUTPUT_REGISTER (0)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (i_fifo_clear),
      .wr_en_i   (wrEn_q),
      .wr_data_i (wrEntry_q),
      .rd_en_i   (i_fifo_rd_en),
      .rd_data_o (rdEntry),
      .empty_o   (fifoEmpty),
      .full_o    (fifoFull)
   );

   // Same acceptance rules the FIFO applies internally, used for the level
   // count, error pulses and timeout restarts.
   assign pushOk = wrEn_q & ~i_fifo_clear & (~fifoFull | i_fifo_rd_en);
   assign popOk  = i_fifo_rd_en & ~i_fifo_clear & ~fifoEmpty;

   // Level counter, threshold flag and error pulses, all registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q     <= '0;
         threshold_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (i_fifo_clear)          level_q <= '0;
         else if (pushOk && !popOk) level_q <= level_q + 1'b1;
         else if (popOk && !pushOk) level_q <= level_q - 1'b1;
         threshold_q <= (i_rx_threshold != '0) && (level_q >= i_rx_threshold);
         overflow_q  <= wrEn_q & fifoFull & ~i_fifo_rd_en & ~i_fifo_clear;
         underflow_q <= i_fifo_rd_en & fifoEmpty & ~i_fifo_clear;
      end
   end

   // Idle timeout: counts os ticks while data waits and nothing is arriving.
   // A new write restarts the count but leaves an asserted flag alone; only a
   // read, a flush or a new start bit clears the flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         toCnt_q   <= '0;
         timeout_q <= 1'b0;
      end else if (i_fifo_clear || popOk || startDet) begin
         toCnt_q   <= '0;
         timeout_q <= 1'b0;
      end else if (wrEn_q) begin
         toCnt_q <= '0;
      end else if (i_os_tick && (state_q == IDLE) && (level_q != '0) && (toCnt_q != TO_MAX)) begin
         toCnt_q <= toCnt_q + 1'b1;
         if (toCnt_q == TO_PRE) timeout_q <= 1'b1;
      end
   end

   assign o_fifo_rd_data    = rdEntry[7:0];
   assign o_fifo_rd_err     = rdEntry[10:8];
   assign o_fifo_empty      = fifoEmpty;
   assign o_fifo_full       = fifoFull;
   assign o_fifo_level      = level_q;
   assign o_threshold       = threshold_q;
   assign o_timeout         = timeout_q;
   assign o_overflow_error  = overflow_q;
   assign o_underflow_error = underflow_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os
// Scoreboard bench for uart_rx_os: frames are built bit by bit from the line
// format rules, the expected FIFO entry is queued when a frame is sent, and a
// monitor compares the FIFO head on every read.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;

   localparam int OS     = 16;
   localparam int DEPTH  = 16;
   localparam int TO_BIT = 40;

   logic       clk;
   logic       rst_n;
   logic       osTick;
   logic       rxLine;
   logic [1:0] dataBits;
   logic       parityEn;
   logic       parityOdd;
   logic       stopBits;
   logic       fifoClear;
   logic       fifoRdEn;
   logic [4:0] rxThreshold;
   logic [7:0] rdData;
   logic [2:0] rdErr;
   logic       fifoEmpty;
   logic       fifoFull;
   logic [4:0] fifoLevel;
   logic       thresholdIrq;
   logic       timeoutIrq;
   logic       overflowErr;
   logic       underflowErr;

   int         checks   = 0;
   int         failures = 0;
   logic [10:0] expQ[$];
   int         expOvf  = 0;
   int         expUdf  = 0;
   int         ovfSeen = 0;
   int         udfSeen = 0;

   uart_rx_os #(
      .FIFO_DEPTH   (DEPTH),
      .OVERSAMPLE   (OS),
      .TIMEOUT_BITS (TO_BIT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_os_tick         (osTick),
      .i_uart_rx         (rxLine),
      .i_data_bits       (dataBits),
      .i_parity_en       (parityEn),
      .i_parity_odd      (parityOdd),
      .i_stop_bits       (stopBits),
      .i_fifo_clear      (fifoClear),
      .i_fifo_rd_en      (fifoRdEn),
      .i_rx_threshold    (rxThreshold),
      .o_fifo_rd_data    (rdData),
      .o_fifo_rd_err     (rdErr),
      .o_fifo_empty      (fifoEmpty),
      .o_fifo_full       (fifoFull),
      .o_fifo_level      (fifoLevel),
      .o_threshold       (thresholdIrq),
      .o_timeout         (timeoutIrq),
      .o_overflow_error  (overflowErr),
      .o_underflow_error (underflowErr)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversample tick: one clock high out of every three.
   initial begin
      osTick = 1'b0;
      forever begin
         repeat (2) @(posedge clk);
         #1 osTick = 1'b1;
         @(posedge clk);
         #1 osTick = 1'b0;
      end
   end

   // Absolute bound on run time.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: counts error pulses and checks the head against the scoreboard
   // whenever a read is presented to a non-empty FIFO.
   always @(negedge clk) begin
      if (rst_n) begin
         if (overflowErr)  ovfSeen++;
         if (underflowErr) udfSeen++;
         if (fifoRdEn && !fifoEmpty) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedEntry", {21'd0, rdErr, rdData}, 32'h7ff);
            end else begin
               checkOutput("rdEntry", {21'd0, rdErr, rdData}, {21'd0, expQ.pop_front()});
            end
         end
      end
   end

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!osTick) @(posedge clk);
      end
      #1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expectEntry(input logic [10:0] e);
      if (expQ.size() >= DEPTH) expOvf++;
      else                      expQ.push_back(e);
   endtask

   // Builds one frame as a list of line levels from the format rules, queues
   // the expected entry, then drives each level for one bit-time.
   task automatic applyStimulus(input logic [7:0] d, input int nb, input bit pe,
                                input bit po, input bit s2, input bit flip,
                                input bit stopLow);
      bit         line[$];
      int         mask;
      logic [7:0] dm;
      bit         pbit;
      bit         isBreak;
      logic [2:0] err;
      mask = (1 << nb) - 1;
      dm   = d & mask[7:0];
      pbit = bit'(($countones(dm) % 2) != 0) ^ po ^ flip;
      isBreak = (dm == 8'd0) && (!pe || !pbit) && stopLow;
      if (isBreak) err = 3'b110;
      else         err = {1'b0, stopLow, pe & flip};
      expectEntry({err, dm});
      line.push_back(1'b0);
      for (int i = 0; i < nb; i++) line.push_back(dm[i]);
      if (pe) line.push_back(pbit);
      line.push_back(!stopLow);
      if (s2) line.push_back(1'b1);
      dataBits  = 2'(nb - 5);
      parityEn  = pe;
      parityOdd = po;
      stopBits  = s2;
      foreach (line[i]) begin
         rxLine = line[i];
         waitTicks(OS);
      end
      rxLine = 1'b1;
      waitTicks(2 * OS);
   endtask

   task automatic send8N1(input logic [7:0] d);
      applyStimulus(d, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic readOne();
      fifoRdEn = 1'b1;
      @(posedge clk);
      #1 fifoRdEn = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nb, k;
      bit pe, po, s2, flip, stopLow;
      logic [7:0] d;

      rst_n       = 1'b0;
      rxLine      = 1'b1;
      dataBits    = 2'd3;
      parityEn    = 1'b0;
      parityOdd   = 1'b0;
      stopBits    = 1'b0;
      fifoClear   = 1'b0;
      fifoRdEn    = 1'b0;
      rxThreshold = 5'd0;
      waitCycles(5);
      rst_n = 1'b1;
      waitCycles(2);

      $display("[TB] reset state");
      checkOutput("rstEmpty", 32'(fifoEmpty), 32'd1);
      checkOutput("rstFull", 32'(fifoFull), 32'd0);
      checkOutput("rstLevel", 32'(fifoLevel), 32'd0);
      checkOutput("rstThreshold", 32'(thresholdIrq), 32'd0);
      checkOutput("rstTimeout", 32'(timeoutIrq), 32'd0);
      waitTicks(1);

      $display("[TB] 8N1 single byte");
      send8N1(8'hA5);
      checkOutput("a5Level", 32'(fifoLevel), 32'd1);
      checkOutput("a5Empty", 32'(fifoEmpty), 32'd0);
      readOne();
      checkOutput("a5EmptyAfterRead", 32'(fifoEmpty), 32'd1);

      $display("[TB] 7E1 parity error then good frame");
      applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("parLevel", 32'(fifoLevel), 32'd2);
      readOne();
      readOne();

      $display("[TB] false start glitch");
      rxLine = 1'b0;
      waitTicks(4);
      rxLine = 1'b1;
      waitTicks(3 * OS);
      checkOutput("glitchLevel", 32'(fifoLevel), 32'd0);
      checkOutput("glitchEmpty", 32'(fifoEmpty), 32'd1);
      send8N1(8'h3C);
      readOne();

      $display("[TB] break then valid byte");
      expectEntry(11'b110_0000_0000);
      rxLine = 1'b0;
      waitTicks(12 * OS);
      rxLine = 1'b1;
      waitTicks(2 * OS);
      checkOutput("breakLevel", 32'(fifoLevel), 32'd1);
      send8N1(8'h5A);
      checkOutput("breakNextLevel", 32'(fifoLevel), 32'd2);
      readOne();
      readOne();

      $display("[TB] overflow and underflow");
      for (int i = 0; i <= DEPTH; i++) send8N1(8'(i));
      checkOutput("ovfLevel", 32'(fifoLevel), 32'(DEPTH));
      checkOutput("ovfFull", 32'(fifoFull), 32'd1);
      checkOutput("ovfPulses", 32'(ovfSeen), 32'(expOvf));
      for (int i = 0; i <= DEPTH; i++) begin
         if (fifoEmpty) expUdf++;
         readOne();
      end
      checkOutput("udfPulses", 32'(udfSeen), 32'(expUdf));
      checkOutput("udfLevel", 32'(fifoLevel), 32'd0);

      $display("[TB] randomized frames");
      for (int b = 0; b < 10; b++) begin
         k = $urandom_range(1, 3);
         for (int f = 0; f < k; f++) begin
            nb      = $urandom_range(5, 8);
            pe      = bit'($urandom_range(0, 1));
            po      = bit'($urandom_range(0, 1));
            s2      = bit'($urandom_range(0, 1));
            flip    = ($urandom_range(0, 3) == 0);
            stopLow = ($urandom_range(0, 5) == 0);
            d       = 8'($urandom_range(0, 255));
            if (stopLow) d[0] = 1'b1;
            applyStimulus(d, nb, pe, po, s2, flip, stopLow);
         end
         checkOutput("batchLevel", 32'(fifoLevel), 32'(expQ.size()));
         for (int f = 0; f < k; f++) readOne();
      end

      $display("[TB] clear, threshold and timeout");
      send8N1(8'h11);
      send8N1(8'h22);
      fifoClear = 1'b1;
      @(posedge clk);
      #1 fifoClear = 1'b0;
      expQ.delete();
      waitCycles(2);
      checkOutput("clearLevel", 32'(fifoLevel), 32'd0);
      checkOutput("clearEmpty", 32'(fifoEmpty), 32'd1);
      rxThreshold = 5'd4;
      for (int i = 0; i < 3; i++) send8N1(8'($urandom_range(0, 255)) | 8'h80);
      checkOutput("thr3", 32'(thresholdIrq), 32'd0);
      send8N1(8'hC3);
      checkOutput("thr4", 32'(thresholdIrq), 32'd1);
      checkOutput("toEarly", 32'(timeoutIrq), 32'd0);
      waitTicks(TO_BIT * OS);
      checkOutput("toSet", 32'(timeoutIrq), 32'd1);
      readOne();
      waitCycles(2);
      checkOutput("thrAfterRead", 32'(thresholdIrq), 32'd0);
      checkOutput("toAfterRead", 32'(timeoutIrq), 32'd0);
      waitTicks(TO_BIT * OS - 40);
      checkOutput("toBeforeLimit", 32'(timeoutIrq), 32'd0);
      waitTicks(60);
      checkOutput("toAtLimit", 32'(timeoutIrq), 32'd1);
      for (int i = 0; i < 3; i++) readOne();
      checkOutput("toAfterDrain", 32'(timeoutIrq), 32'd0);
      checkOutput("finalLevel", 32'(fifoLevel), 32'd0);

      checkOutput("scoreboardLeft", 32'(expQ.size()), 32'd0);
      checkOutput("finalOvf", 32'(ovfSeen), 32'(expOvf));
      checkOutput("finalUdf", 32'(udfSeen), 32'(expUdf));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
